// File: rtl/accel_spi_pkg.sv
// Shared constants for the accelerometer SPI framing: instruction codes,
// register addresses, FSM state encoding, the X/Y/Z sample record and the
// helpers that split a 12-bit sample into its low/high register bytes.
package accel_spi_pkg;

  localparam int SAMPLE_W = 12;

  localparam logic [7:0] INSTR_WRITE = 8'h0A;
  localparam logic [7:0] INSTR_READ  = 8'h0B;

  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
  localparam logic [5:0] ADDR_POWER_CTL = 6'h2D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] x;
    logic signed [SAMPLE_W-1:0] y;
    logic signed [SAMPLE_W-1:0] z;
  } sample_t;

  function automatic logic [7:0] lo_byte(input logic signed [SAMPLE_W-1:0] s);
    return s[7:0];
  endfunction

  // High register byte is the top nibble sign-extended to a full byte.
  function automatic logic [7:0] hi_byte(input logic signed [SAMPLE_W-1:0] s);
    return {{4{s[SAMPLE_W-1]}}, s[SAMPLE_W-1:8]};
  endfunction

endpackage

// File: rtl/accel_resp_regs.sv
// Register file of the accelerometer stand-in: sample staging, the per-frame
// shadow copy, POWER_CTL and the read multiplexer.
module accel_resp_regs
  import accel_spi_pkg::*;
#(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2
) (
  input  logic                       clk_SPI,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] x_in,
  input  logic signed [SAMPLE_W-1:0] y_in,
  input  logic signed [SAMPLE_W-1:0] z_in,
  input  logic                       snap,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic [5:0]                 rd_addr,
  output logic [7:0]                 rd_data,
  output logic [7:0]                 power_ctl,
  output logic                       measuring
);

  sample_t    staging_q, staging_d;
  sample_t    shadow_q, shadow_d;
  logic [7:0] power_ctl_q, power_ctl_d;

  // Staging follows every strobe; shadow only moves at frame start so a burst sees one sample set.
  always_comb begin
    staging_d   = staging_q;
    shadow_d    = shadow_q;
    power_ctl_d = power_ctl_q;
    if (sample_valid) begin
      staging_d.x = x_in;
      staging_d.y = y_in;
      staging_d.z = z_in;
    end
    if (snap)  shadow_d    = staging_q;
    if (wr_en) power_ctl_d = wr_data;
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk_SPI) begin
    if (!reset) begin
      staging_q   <= '0;
      shadow_q    <= '0;
      power_ctl_q <= 8'h00;
    end else begin
      staging_q   <= staging_d;
      shadow_q    <= shadow_d;
      power_ctl_q <= power_ctl_d;
    end
  end

  assign power_ctl = power_ctl_q;
  assign measuring = (power_ctl_q[1:0] == 2'b10);

  // Read map; sample registers read as zero unless the part is measuring.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_DEVID_AD:  rd_data = DEVID_AD;
      ADDR_DEVID_MST: rd_data = DEVID_MST;
      ADDR_PARTID:    rd_data = PARTID;
      ADDR_XDATA_L:   if (measuring) rd_data = lo_byte(shadow_q.x);
      ADDR_XDATA_H:   if (measuring) rd_data = hi_byte(shadow_q.x);
      ADDR_YDATA_L:   if (measuring) rd_data = lo_byte(shadow_q.y);
      ADDR_YDATA_H:   if (measuring) rd_data = hi_byte(shadow_q.y);
      ADDR_ZDATA_L:   if (measuring) rd_data = lo_byte(shadow_q.z);
      ADDR_ZDATA_H:   if (measuring) rd_data = hi_byte(shadow_q.z);
      ADDR_POWER_CTL: rd_data = power_ctl_q;
      default:        rd_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/accel_spi_responder.sv
// SPI responder standing in for the accelerometer. Serial FSM, bit counter
// and the negedge MISO register live here; registers are in accel_resp_regs.
// Build option: define ACCEL_RESP_AUTOINC_EN to auto-increment the address
// across multi-byte bursts; otherwise the frame is ignored after one data byte.
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2
) (
  input  logic                       clk_SPI,
  input  logic                       reset,
  input  logic                       n_CS,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic signed [SAMPLE_W-1:0] x_in,
  input  logic signed [SAMPLE_W-1:0] y_in,
  input  logic signed [SAMPLE_W-1:0] z_in,
  input  logic                       sample_valid,
  output logic [7:0]                 power_ctl,
  output logic                       measuring,
  output logic                       txn_done
);

  state_t     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] sr_q, sr_d;
  logic [5:0] addr_q, addr_d;
  logic       wr_mode_q, wr_mode_d;
  logic       load_q, load_d;
  logic       armed_q, armed_d;
  logic       txn_done_q, txn_done_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic       snap, wr_en;
  logic [7:0] rd_data;

  accel_resp_regs #(
    .DEVID_AD  (DEVID_AD),
    .DEVID_MST (DEVID_MST),
    .PARTID    (PARTID)
  ) u_regs (
    .clk_SPI      (clk_SPI),
    .reset        (reset),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .snap         (snap),
    .wr_en        (wr_en),
    .wr_data      (sr_d),
    .rd_addr      (addr_q),
    .rd_data      (rd_data),
    .power_ctl    (power_ctl),
    .measuring    (measuring)
  );

  // Posedge next-state: CS high aborts any frame; otherwise shift MOSI and step the byte FSM.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    sr_d       = {sr_q[6:0], MOSI};
    addr_d     = addr_q;
    wr_mode_d  = wr_mode_q;
    load_d     = 1'b0;
    armed_d    = armed_q | n_CS;
    txn_done_d = 1'b0;
    snap       = 1'b0;
    wr_en      = 1'b0;
    if (n_CS) begin
      txn_done_d = (state_q != S_IDLE);
      state_d    = S_IDLE;
      bitcnt_d   = 3'd7;
    end else begin
      case (state_q)
        S_IDLE: begin
          // After reset, a frame may only start once CS has been seen high.
          if (armed_q) begin
            state_d  = S_INSTR;
            bitcnt_d = 3'd6;
            snap     = 1'b1;
          end
        end
        S_INSTR: begin
          if (bitcnt_q == 3'd0) begin
            bitcnt_d = 3'd7;
            if (sr_d == INSTR_WRITE) begin
              state_d   = S_ADDR;
              wr_mode_d = 1'b1;
            end else if (sr_d == INSTR_READ) begin
              state_d   = S_ADDR;
              wr_mode_d = 1'b0;
            end else begin
              state_d = S_IGNORE;
            end
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
        S_ADDR: begin
          if (bitcnt_q == 3'd0) begin
            bitcnt_d = 3'd7;
            addr_d   = sr_d[5:0];
            state_d  = wr_mode_q ? S_WDATA : S_RDATA;
            load_d   = ~wr_mode_q;
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
        S_WDATA, S_RDATA: begin
          if (bitcnt_q == 3'd0) begin
            bitcnt_d = 3'd7;
            wr_en    = (state_q == S_WDATA) && (addr_q == ADDR_POWER_CTL);
`ifdef ACCEL_RESP_AUTOINC_EN
            addr_d   = addr_q + 6'd1;
            load_d   = (state_q == S_RDATA);
`else
            state_d  = S_IGNORE;
`endif
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
        S_IGNORE: state_d = S_IGNORE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Control registers on the MOSI sampling edge.
  always_ff @(posedge clk_SPI) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= 3'd7;
      addr_q     <= 6'd0;
      wr_mode_q  <= 1'b0;
      load_q     <= 1'b0;
      armed_q    <= 1'b0;
      txn_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      addr_q     <= addr_d;
      wr_mode_q  <= wr_mode_d;
      load_q     <= load_d;
      armed_q    <= armed_d;
      txn_done_q <= txn_done_d;
    end
  end

  // Incoming shift register; contents are only consumed at byte boundaries.
  always_ff @(posedge clk_SPI) begin
    sr_q <= sr_d;
  end

  // Negedge transmit path: load a fresh byte after each byte boundary, else walk it MSB first.
  always_comb begin
    tx_d   = tx_q;
    miso_d = 1'b0;
    if (!n_CS && (state_q == S_RDATA)) begin
      if (load_q) begin
        tx_d   = rd_data;
        miso_d = rd_data[7];
      end else begin
        miso_d = tx_q[bitcnt_q];
      end
    end
  end

  // MISO register changes on the falling edge so the initiator samples it mid-bit.
  always_ff @(negedge clk_SPI) begin
    if (!reset) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= miso_d;
    end
  end

  // Transmit byte holding register.
  always_ff @(negedge clk_SPI) begin
    tx_q <= tx_d;
  end

  assign MISO     = miso_q;
  assign txn_done = txn_done_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder acting as the SPI initiator:
// MOSI/n_CS driven just after the falling edge, MISO sampled just after the
// rising edge. Burst expectations follow ACCEL_RESP_AUTOINC_EN.
module tb_accel_spi_responder;

  logic              clk_SPI = 1'b0;
  logic              reset = 1'b0;
  logic              n_CS = 1'b1;
  logic              MOSI = 1'b0;
  logic              MISO;
  logic signed [11:0] x_in = '0;
  logic signed [11:0] y_in = '0;
  logic signed [11:0] z_in = '0;
  logic              sample_valid = 1'b0;
  logic [7:0]        power_ctl;
  logic              measuring;
  logic              txn_done;

  int checks = 0;
  int errors = 0;

  accel_spi_responder dut (
    .clk_SPI      (clk_SPI),
    .reset        (reset),
    .n_CS         (n_CS),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .measuring    (measuring),
    .txn_done     (txn_done)
  );

  always #5 clk_SPI = ~clk_SPI;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic [7:0] sh;
    sh = tx;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_SPI); #1;
      n_CS = 1'b0;
      MOSI = sh[7];
      sh   = {sh[6:0], 1'b0};
      @(posedge clk_SPI); #1;
      rx = {rx[6:0], MISO};
    end
  endtask

  task automatic cs_high();
    @(negedge clk_SPI); #1;
    n_CS = 1'b1;
    MOSI = 1'b0;
    @(posedge clk_SPI); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_SPI); #1;
    end
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [7:0] data);
    logic [7:0] dummy;
    spi_bits(8'h0B, 8, dummy);
    spi_bits(addr, 8, dummy);
    spi_bits(8'h00, 8, data);
    cs_high();
    idle(1);
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] dummy;
    spi_bits(8'h0A, 8, dummy);
    spi_bits(addr, 8, dummy);
    spi_bits(data, 8, dummy);
    cs_high();
    idle(1);
  endtask

  logic [7:0] rx;
  logic [7:0] burst_exp [6];

  initial begin
    // Reset with CS idle high
    reset = 1'b0;
    n_CS  = 1'b1;
    idle(3);
    check1("rst_miso", MISO, 1'b0);
    check8("rst_power_ctl", power_ctl, 8'h00);
    check1("rst_measuring", measuring, 1'b0);
    check1("rst_txn_done", txn_done, 1'b0);
    @(negedge clk_SPI); #1;
    reset = 1'b1;
    idle(2);

    // Device ID read with txn_done pulse
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    check8("devid_ad", rx, 8'hAD);
    cs_high();
    check1("txn_done_pulse", txn_done, 1'b1);
    idle(1);
    check1("txn_done_single", txn_done, 1'b0);
    read_reg(8'h01, rx);
    check8("devid_mst", rx, 8'h1D);
    read_reg(8'h02, rx);
    check8("partid", rx, 8'hF2);

    // POWER_CTL write commits on the data bit-0 edge
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h02, 8, rx);
    check8("pctl_write", power_ctl, 8'h02);
    check1("measuring_on", measuring, 1'b1);
    cs_high();
    idle(1);
    read_reg(8'h2D, rx);
    check8("pctl_readback", rx, 8'h02);

    // Burst sample read from 0x0E
    x_in = 12'hF85;
    y_in = 12'h07B;
    z_in = 12'h400;
    @(negedge clk_SPI); #1;
    sample_valid = 1'b1;
    @(negedge clk_SPI); #1;
    sample_valid = 1'b0;
    idle(1);
`ifdef ACCEL_RESP_AUTOINC_EN
    burst_exp = '{8'h85, 8'hFF, 8'h7B, 8'h00, 8'h00, 8'h04};
`else
    burst_exp = '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h0E, 8, rx);
    for (int i = 0; i < 6; i++) begin
      spi_bits(8'h00, 8, rx);
      check8($sformatf("burst_byte%0d", i), rx, burst_exp[i]);
    end
    cs_high();
    idle(1);

    // Writes to read-only addresses are dropped
    write_reg(8'h00, 8'hFF);
    check8("ro_write_ignored", power_ctl, 8'h02);

    // Coherence: a mid-frame sample strobe does not disturb the current frame
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h0E, 8, rx);
    spi_bits(8'h00, 8, rx);
    check8("coh_x_lo_old", rx, 8'h85);
    x_in = 12'h123;
    sample_valid = 1'b1;
    spi_bits(8'h00, 8, rx);
    sample_valid = 1'b0;
`ifdef ACCEL_RESP_AUTOINC_EN
    check8("coh_x_hi_old", rx, 8'hFF);
`else
    check8("coh_x_hi_old", rx, 8'h00);
`endif
    cs_high();
    idle(1);
    read_reg(8'h0E, rx);
    check8("coh_x_lo_new", rx, 8'h23);
    read_reg(8'h0F, rx);
    check8("coh_x_hi_new", rx, 8'h01);

    // Measurement gating
    write_reg(8'h2D, 8'h00);
    check1("measuring_off", measuring, 1'b0);
    read_reg(8'h0E, rx);
    check8("gated_x_lo", rx, 8'h00);
    write_reg(8'h2D, 8'h03);
    check8("pctl_03", power_ctl, 8'h03);
    check1("measuring_mode3", measuring, 1'b0);

    // Abort after 4 data bits of a POWER_CTL write
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'hF0, 4, rx);
    cs_high();
    check1("abort_txn_done", txn_done, 1'b1);
    idle(1);
    check8("abort_pctl", power_ctl, 8'h03);
    read_reg(8'h00, rx);
    check8("after_abort_read", rx, 8'hAD);

    // Illegal instruction keeps MISO low for the whole frame
    spi_bits(8'h0C, 8, rx);
    spi_bits(8'h00, 8, rx);
    check8("illegal_addr_miso", rx, 8'h00);
    spi_bits(8'h00, 8, rx);
    check8("illegal_data_miso", rx, 8'h00);
    cs_high();
    check1("illegal_txn_done", txn_done, 1'b1);
    idle(1);

    // Reset during an RDATA byte, CS held low throughout
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 3, rx);
    check8("pre_reset_bits", rx, 8'h05);
    @(negedge clk_SPI); #1;
    reset = 1'b0;
    idle(2);
    check1("midrst_miso", MISO, 1'b0);
    check8("midrst_pctl", power_ctl, 8'h00);
    check1("midrst_measuring", measuring, 1'b0);
    check1("midrst_txn_done", txn_done, 1'b0);
    @(negedge clk_SPI); #1;
    reset = 1'b1;
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h02, 8, rx);
    check8("unarmed_pctl", power_ctl, 8'h00);
    check8("unarmed_miso", rx, 8'h00);
    cs_high();
    check1("unarmed_txn_done", txn_done, 1'b0);
    idle(1);
    read_reg(8'h00, rx);
    check8("rearmed_read", rx, 8'hAD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_spi_responder.md
# accel_spi_responder

SPI responder that models the accelerometer's register interface from the chip side, answering the same instruction/address/data framing our SPI initiator issues. Used as the on-board stand-in for the accelerometer in simulation and in loop-back builds. Connecting it directly to `spi_interface` lets the maze game run without the physical sensor. X/Y/Z samples come from a pattern source, and the block serves them to the initiator as 12-bit two's-complement register pairs.

## Interface
- `DEVID_AD`, 8'hAD: value returned at address 0x00.
- `DEVID_MST`, 8'h1D: value returned at address 0x01.
- `PARTID`, 8'hF2: value returned at address 0x02.
- `clk_SPI`  in  1  SPI clock, shared with the initiator's SCLK. MOSI is sampled on the posedge; MISO changes on the negedge.
- `reset`  in  1  Synchronous, active-low.
- `n_CS`  in  1  Chip select, active low.
- `MOSI`  in  1  Serial data from the initiator, MSB first.
- `MISO`  out  1  Serial data to the initiator. Registered on the negedge.
- `x_in`, `y_in`, `z_in`  in  12 each  Sample values, two's complement.
- `sample_valid`  in  1  One-cycle strobe that loads x/y/z into the staging register.
- `power_ctl`  out  8  POWER_CTL register (0x2D).
- `measuring`  out  1  High when `power_ctl[1:0] == 2'b10`.
- `txn_done`  out  1  One-cycle pulse on the first posedge at which `n_CS` is seen high after a transaction.

## Operation
- **States:** IDLE, INSTR, ADDR, WDATA, RDATA, IGNORE.
- **Bit counter:** 3-bit `bitcnt` counts 7 down to 0. At 0 the byte completes and the counter reloads to 7.
- **IDLE:**
  - On the first posedge with `n_CS == 0`, sample MOSI as instruction bit 7 and go to INSTR.
  - Snapshot staging into `shadow` on that same edge.
- **INSTR:**
  - 8'h0A goes to ADDR with write mode; 8'h0B goes to ADDR with read mode.
  - Any other value goes to IGNORE.
- **ADDR:**
  - Latch `addr[5:0]`; bits 7:6 are ignored.
  - Then go to WDATA or RDATA.
- **RDATA:**
  - On the negedge after each address/byte-final posedge, load `tx = rd_mux(addr)` and drive `tx[7]`.
  - Subsequent negedges drive `tx[6:0]` MSB first.
- **WDATA:**
  - Shift MOSI in. On byte completion, write only if `addr == 0x2D`; every other address is read-only and the write is ignored.
- **After each data byte:**
  - `addr <= addr + 1`, wrapping 0x3F to 0x00 (see Configuration).
  - Remain in RDATA/WDATA.
- **Read map (`rd_mux`):**
  - 0x00/0x01/0x02 return the parameters.
  - 0x0E/0x0F return X low / high.
  - 0x10/0x11 return Y low / high.
  - 0x12/0x13 return Z low / high.
  - 0x2D returns `power_ctl`.
  - All other addresses return 8'h00.
- **Data byte format:**
  - Low byte = `s[7:0]`.
  - High byte = `{ {4{s[11]}}, s[11:8] }` (sign-extended).
- **Measurement gating:** when `measuring == 0`, 0x0E–0x13 read 8'h00.
- **IGNORE:** MISO held 0 until `n_CS` rises.
- **`n_CS` rising in any state:**
  - Return to IDLE, reload `bitcnt` to 7, and discard any partial byte (no register write).
  - MISO goes 0 on the next negedge.
- **`sample_valid`:** always loads staging, including mid-transaction. `shadow` changes only at a transaction start, so X/Y/Z reads within one CS frame are coherent.

## Timing
- **Reset values:**
  - MISO = 0, `power_ctl` = 8'h00, `measuring` = 0, `txn_done` = 0.
  - State = IDLE, `bitcnt` = 7, `addr` = 0.
  - `shadow` and staging = 0.
- **Reset priority:** reset overrides everything. Reset asserted mid-transaction returns the block to IDLE even with `n_CS` low; the block then re-arms only after `n_CS` goes high.
- **Read latency:** after the posedge that samples address bit 0, data bit 7 is valid from the following negedge and is sampled by the initiator on the next posedge.
- **Write commit:** the POWER_CTL write takes effect on the posedge that samples data bit 0. `measuring` follows on the same edge, combinationally from the register.
- **`txn_done`:** high for exactly one clk_SPI cycle per CS frame.

## Configuration
- **`ACCEL_RESP_AUTOINC_EN` defined:** multi-byte bursts auto-increment the address as described in Operation (for example, 0x0E..0x13 in a single frame).
- **Undefined:** after the first data byte the FSM enters IGNORE. Further read bytes return 8'h00, and further write bytes are discarded.

## Structure
- **Shared package `accel_spi_pkg`:**
  - Register address constants: 0x00, 0x01, 0x02, 0x0E–0x13, 0x2D.
  - Instruction constants 8'h0A / 8'h0B.
  - The state encoding.
  - The initiator should adopt the same constants.
- **Sub-module `accel_resp_regs`:** holds staging, `shadow`, `power_ctl` and `rd_mux`. The top level keeps the serial FSM, `bitcnt` and the MISO negedge register.

## Test plan
- **Device ID read:** frame 0x0B, 0x00, read one byte → MISO returns 8'hAD; `txn_done` pulses once after `n_CS` rises.
- **POWER_CTL write and read-back:** frame 0x0A, 0x2D, 0x02 → `power_ctl` = 8'h02 and `measuring` = 1 on the data bit-0 posedge. Then frame 0x0B, 0x2D → 8'h02.
- **Burst sample read:** `x_in` = 12'hF85 (−123), `y_in` = 12'h07B, `z_in` = 12'h400, measuring on, burst read from 0x0E for 6 bytes → 0x85, 0xFF, 0x7B, 0x00, 0x00, 0x04. Without the macro → 0x85 then 0x00 ×5.
- **Gating and coherence:** measuring off, read 0x0E → 0x00. Pulse `sample_valid` mid-burst → values within the frame are unchanged; the next frame shows the new values.
- **Abort mid-byte:** raise `n_CS` after 4 data bits of a 0x2D write → `power_ctl` unchanged; the next transaction decodes correctly.
- **Illegal instruction and reset:** instruction 8'h0C → MISO 0 for the whole frame. Reset asserted during an RDATA byte → all outputs at reset values, and the block responds normally after `n_CS` toggles.
